traffic_phase_timer: RTL and testbench
======================================

Name: traffic_phase_timer

Overview:
- Interval timer that sequences traffic_light_controller by generating its timer_done input.
- Decodes the current phase from the controller's traffic_out, loads a per-phase duration, counts it down in prescaled ticks, and asserts timer_done when the duration expires.
- Per-phase durations are runtime-reconfigurable through a simple write port.
- Sits beside traffic_light_controller: traffic_out feeds in, timer_done feeds back.

Parameters:
- CNT_W, 8: width of duration registers and tick counter.
- PRESCALE, 100: clk cycles per tick (≥1).
- GARB_TICKS, 60: reset duration of green-A/red-B.
- AARB_TICKS, 5: reset duration of amber-A/red-B.
- RAGB_TICKS, 40: reset duration of red-A/green-B.
- RAAB_TICKS, 5: reset duration of red-A/amber-B.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- traffic_out  in  7  controller light outputs: [6:4]={redA,amberA,greenA}, [3:1]={redB,amberB,greenB}, [0] ignored.
- enable  in  1  1 = count; 0 = freeze prescaler and counter.
- cfg_we  in  1  duration write strobe, one cycle.
- cfg_sel  in  2  duration select: 0=GARB, 1=AARB, 2=RAGB, 3=RAAB.
- cfg_data  in  CNT_W  new duration in ticks.
- timer_done  out  1  current phase duration expired.
- phase  out  2  registered phase code (same encoding as cfg_sel).
- remaining  out  CNT_W  ticks left in current phase.
- phase_err  out  1  sticky illegal-light-pattern flag.

Behaviour:
- One clock; reset is asynchronous and active-low (rstn); all state clears immediately on rstn=0, independent of clk.
- Reset values:
  - phase=0 (GARB).
  - remaining=GARB_TICKS (0 loads as 1).
  - prescaler=0, phase_err=0, timer_done=0.
  - dur[0..3]=the four parameters.
- Decode (combinational) of traffic_out[6:1]; any other pattern is illegal:
  - 001_100 = GARB.
  - 010_100 = AARB.
  - 100_001 = RAGB.
  - 100_010 = RAAB.
- Phase change: when decoded is legal and differs from phase, on the next edge:
  - phase<=decoded.
  - remaining<=dur[decoded] (0 loads as 1).
  - prescaler<=0.
- Tick rule:
  - The prescaler counts 0..PRESCALE-1 while enable=1 and no phase change is pending.
  - A tick occurs on the cycle prescaler==PRESCALE-1; the prescaler then wraps to 0.
  - On a tick with remaining>0, remaining decrements by 1. remaining never wraps below 0 and holds at 0.
- timer_done is combinational: (remaining==0) && (decoded==phase) && decoded legal && !phase_err.
  - It drops in the same cycle traffic_out changes phase, so the controller never sees a stale done.
  - It stays high for as long as the phase is unchanged.
- Latency: with enable held at 1, timer_done rises exactly dur×PRESCALE cycles after the reload edge.
- enable=0 freezes the prescaler and remaining. Phase-change reloads still occur. timer_done is not gated by enable.
- Config writes:
  - cfg_we=1 writes dur[cfg_sel]<=cfg_data on the next edge.
  - The write never alters the running count; it takes effect at the next entry into that phase.
  - A write coinciding with a reload into the same phase loads the new value.
- Illegal pattern: phase_err<=1 on the next edge and stays set until reset.
  - While traffic_out is illegal, remaining and the prescaler hold.
  - After phase_err is set, counting and reloads continue normally, but timer_done is forced to 0 until reset (fail-safe: controller holds its phase).
- Reset mid-count: state returns to reset values immediately; dur registers revert to the parameters.

Test Plan:
- Bench parameters: PRESCALE=2, GARB_TICKS=3, AARB_TICKS=2, RAGB_TICKS=4, RAAB_TICKS=2, enable=1 unless stated.
- Reset: assert rstn=0 mid-count, off a clock edge -> immediately timer_done=0, phase=0, remaining=3, phase_err=0.
- GARB countdown: traffic_out=7'b0011000 after reset release -> remaining steps 3,2,1,0 every 2 cycles; timer_done=1 at cycle 6 and holds while pattern unchanged.
- Phase change: with timer_done=1, drive 7'b0101000 (AARB) -> timer_done=0 same cycle; next edge phase=1, remaining=2; done again 4 cycles later.
- Config: write cfg_sel=2, cfg_data=7 while in RAGB (7'b1000010) with remaining=3 -> count continues 3,2,1,0. Next RAGB entry loads 7. Write cfg_data=0 to sel 3 -> RAAB loads 1.
- Freeze: enable=0 for 10 cycles at remaining=2 -> remaining stays 2, prescaler frozen; resume -> done after 4 more cycles.
- Illegal pattern: drive traffic_out=7'b0000000 -> phase_err=1 next edge, timer_done=0, remaining held. Restore GARB pattern -> counting resumes but timer_done stays 0 and phase_err stays 1 until rstn pulse.

Source files
------------

// File: rtl/traffic_phase_timer.sv
// ============================================================================
// Module      : traffic_phase_timer
// Description : Interval timer that paces traffic_light_controller. It decodes
//               the active phase from the light outputs, reloads a per-phase
//               duration, counts it down in prescaled ticks and raises
//               timer_done when the phase time has expired.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module traffic_phase_timer #(
    parameter int CNT_W      = 8,
    parameter int PRESCALE   = 100,
    parameter int GARB_TICKS = 60,
    parameter int AARB_TICKS = 5,
    parameter int RAGB_TICKS = 40,
    parameter int RAAB_TICKS = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       traffic_out,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             timer_done,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_err
);

    // Phase encoding, shared with cfg_sel.
    localparam logic [1:0] c_garb = 2'd0;
    localparam logic [1:0] c_aarb = 2'd1;
    localparam logic [1:0] c_ragb = 2'd2;
    localparam logic [1:0] c_raab = 2'd3;

    // Prescaler sizing; a prescale of 1 still keeps a one-bit counter stuck at 0.
    localparam int c_ps_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_ps_w-1:0] c_ps_max = c_ps_w'(PRESCALE - 1);

    localparam logic [CNT_W-1:0] c_garb_dur = CNT_W'(GARB_TICKS);
    localparam logic [CNT_W-1:0] c_aarb_dur = CNT_W'(AARB_TICKS);
    localparam logic [CNT_W-1:0] c_ragb_dur = CNT_W'(RAGB_TICKS);
    localparam logic [CNT_W-1:0] c_raab_dur = CNT_W'(RAAB_TICKS);

    // A zero duration would expire instantly; it is treated as one tick.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    logic [1:0]        r_phase;
    logic [CNT_W-1:0]  r_remaining;
    logic [c_ps_w-1:0] r_prescale;
    logic              r_phase_err;
    logic [CNT_W-1:0]  r_dur [4];

    logic [1:0]        w_decoded;
    logic              w_legal;
    logic              w_change;
    logic [CNT_W-1:0]  w_reload;
    logic [1:0]        w_phase_nxt;
    logic [CNT_W-1:0]  w_remaining_nxt;
    logic [c_ps_w-1:0] w_prescale_nxt;
    logic              w_err_nxt;
    logic              w_unused;

    // Bit 0 of the controller output carries no light information.
    assign w_unused = traffic_out[0];

    // Light pattern decode; anything outside the four legal patterns is a fault.
    always_comb begin
        w_decoded = c_garb;
        w_legal   = 1'b1;
        case (traffic_out[6:1])
            6'b001_100: w_decoded = c_garb;
            6'b010_100: w_decoded = c_aarb;
            6'b100_001: w_decoded = c_ragb;
            6'b100_010: w_decoded = c_raab;
            default:    w_legal   = 1'b0;
        endcase
    end

    // Duration bank; a write arriving with a reload into the same phase is
    // forwarded so the new value is the one loaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dur[0] <= c_garb_dur;
            r_dur[1] <= c_aarb_dur;
            r_dur[2] <= c_ragb_dur;
            r_dur[3] <= c_raab_dur;
        end else if (cfg_we) begin
            r_dur[cfg_sel] <= cfg_data;
        end
    end

    assign w_change = w_legal && (w_decoded != r_phase);
    assign w_reload = f_load((cfg_we && (cfg_sel == w_decoded)) ? cfg_data
                                                                 : r_dur[w_decoded]);

    // Next-state: reload on phase entry, otherwise tick down while enabled and legal.
    always_comb begin
        w_phase_nxt     = r_phase;
        w_remaining_nxt = r_remaining;
        w_prescale_nxt  = r_prescale;
        w_err_nxt       = r_phase_err | ~w_legal;
        if (w_change) begin
            w_phase_nxt     = w_decoded;
            w_remaining_nxt = w_reload;
            w_prescale_nxt  = '0;
        end else if (w_legal && enable) begin
            if (r_prescale == c_ps_max) begin
                w_prescale_nxt = '0;
                if (r_remaining != '0) begin
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                end
            end else begin
                w_prescale_nxt = r_prescale + c_ps_w'(1);
            end
        end
    end

    // State register with asynchronous clear to the power-on phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase     <= c_garb;
            r_remaining <= f_load(c_garb_dur);
            r_prescale  <= '0;
            r_phase_err <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_remaining <= w_remaining_nxt;
            r_prescale  <= w_prescale_nxt;
            r_phase_err <= w_err_nxt;
        end
    end

    // Outputs; done drops the same cycle the lights move so it is never stale.
    always_comb begin
        timer_done = (r_remaining == '0) && w_legal && (w_decoded == r_phase)
                     && !r_phase_err;
        phase      = r_phase;
        remaining  = r_remaining;
        phase_err  = r_phase_err;
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
// ============================================================================
// Module      : tb_traffic_phase_timer
// Description : Directed self-checking bench for traffic_phase_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_phase_timer;

    localparam int CNT_W = 8;

    localparam logic [6:0] c_pat_garb = 7'b0011000;
    localparam logic [6:0] c_pat_aarb = 7'b0101000;
    localparam logic [6:0] c_pat_ragb = 7'b1000010;
    localparam logic [6:0] c_pat_raab = 7'b1000100;
    localparam logic [6:0] c_pat_bad  = 7'b0000000;

    logic             clk = 1'b0;
    logic             rstn;
    logic [6:0]       traffic_out;
    logic             enable;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;
    logic             timer_done;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic             phase_err;

    int tests_run    = 0;
    int tests_failed = 0;

    traffic_phase_timer #(
        .CNT_W      (CNT_W),
        .PRESCALE   (2),
        .GARB_TICKS (3),
        .AARB_TICKS (2),
        .RAGB_TICKS (4),
        .RAAB_TICKS (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .traffic_out (traffic_out),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .timer_done  (timer_done),
        .phase       (phase),
        .remaining   (remaining),
        .phase_err   (phase_err)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0; traffic_out = c_pat_garb; enable = 1'b1;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
        step(2);
        rstn = 1'b1;
        step(3);
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (timer_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", timer_done); end
        tests_run++;
        if (phase !== 2'd0) begin tests_failed++; $display("FAIL reset_phase got %0d want 0", phase); end
        tests_run++;
        if (remaining !== 8'd3) begin tests_failed++; $display("FAIL reset_remaining got %0d want 3", remaining); end
        tests_run++;
        if (phase_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", phase_err); end
        step(2);
        rstn = 1'b1;
    endtask

    task automatic test_garb_countdown;
        logic [CNT_W-1:0] exp_rem;
        logic             exp_done;
        tests_run++;
        if (remaining !== 8'd3 || timer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL garb_start got rem=%0d done=%b want rem=3 done=0", remaining, timer_done);
        end
        for (int n = 1; n <= 8; n++) begin
            step(1);
            exp_rem  = (n >= 6) ? 8'd0 : CNT_W'(3 - n / 2);
            exp_done = (n >= 6);
            tests_run++;
            if (remaining !== exp_rem || timer_done !== exp_done) begin
                tests_failed++;
                $display("FAIL garb_cycle%0d got rem=%0d done=%b want rem=%0d done=%b",
                         n, remaining, timer_done, exp_rem, exp_done);
            end
        end
    endtask

    task automatic test_phase_change;
        traffic_out = c_pat_aarb;
        #1;
        tests_run++;
        if (timer_done !== 1'b0) begin tests_failed++; $display("FAIL change_done_drop got %b want 0", timer_done); end
        step(1);
        tests_run++;
        if (phase !== 2'd1 || remaining !== 8'd2) begin
            tests_failed++;
            $display("FAIL change_reload got phase=%0d rem=%0d want phase=1 rem=2", phase, remaining);
        end
        step(3);
        tests_run++;
        if (timer_done !== 1'b0 || remaining !== 8'd1) begin
            tests_failed++;
            $display("FAIL change_early got done=%b rem=%0d want done=0 rem=1", timer_done, remaining);
        end
        step(1);
        tests_run++;
        if (timer_done !== 1'b1 || remaining !== 8'd0) begin
            tests_failed++;
            $display("FAIL change_done got done=%b rem=%0d want done=1 rem=0", timer_done, remaining);
        end
    endtask

    task automatic test_config;
        traffic_out = c_pat_ragb;
        step(1);
        tests_run++;
        if (phase !== 2'd2 || remaining !== 8'd4) begin
            tests_failed++;
            $display("FAIL cfg_ragb_entry got phase=%0d rem=%0d want phase=2 rem=4", phase, remaining);
        end
        step(2);
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 8'd7;
        step(1);
        cfg_we = 1'b0;
        tests_run++;
        if (remaining !== 8'd3) begin tests_failed++; $display("FAIL cfg_no_disturb got %0d want 3", remaining); end
        step(1);
        tests_run++;
        if (remaining !== 8'd2) begin tests_failed++; $display("FAIL cfg_count2 got %0d want 2", remaining); end
        step(4);
        tests_run++;
        if (remaining !== 8'd0 || timer_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_ragb_done got rem=%0d done=%b want rem=0 done=1", remaining, timer_done);
        end
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 8'd0;
        step(1);
        cfg_we = 1'b0;
        traffic_out = c_pat_raab;
        step(1);
        tests_run++;
        if (phase !== 2'd3 || remaining !== 8'd1) begin
            tests_failed++;
            $display("FAIL cfg_zero_load got phase=%0d rem=%0d want phase=3 rem=1", phase, remaining);
        end
        traffic_out = c_pat_ragb;
        step(1);
        tests_run++;
        if (phase !== 2'd2 || remaining !== 8'd7) begin
            tests_failed++;
            $display("FAIL cfg_new_load got phase=%0d rem=%0d want phase=2 rem=7", phase, remaining);
        end
        traffic_out = c_pat_raab;
        cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 8'd5;
        step(1);
        cfg_we = 1'b0;
        tests_run++;
        if (phase !== 2'd3 || remaining !== 8'd5) begin
            tests_failed++;
            $display("FAIL cfg_coincident got phase=%0d rem=%0d want phase=3 rem=5", phase, remaining);
        end
    endtask

    task automatic test_freeze;
        step(6);
        tests_run++;
        if (remaining !== 8'd2) begin tests_failed++; $display("FAIL freeze_pre got %0d want 2", remaining); end
        enable = 1'b0;
        step(10);
        tests_run++;
        if (remaining !== 8'd2 || timer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_hold got rem=%0d done=%b want rem=2 done=0", remaining, timer_done);
        end
        enable = 1'b1;
        step(3);
        tests_run++;
        if (remaining !== 8'd1 || timer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL freeze_resume got rem=%0d done=%b want rem=1 done=0", remaining, timer_done);
        end
        step(1);
        tests_run++;
        if (remaining !== 8'd0 || timer_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL freeze_done got rem=%0d done=%b want rem=0 done=1", remaining, timer_done);
        end
    endtask

    task automatic test_illegal;
        traffic_out = c_pat_garb;
        step(1);
        tests_run++;
        if (phase !== 2'd0 || remaining !== 8'd3) begin
            tests_failed++;
            $display("FAIL illegal_entry got phase=%0d rem=%0d want phase=0 rem=3", phase, remaining);
        end
        step(3);
        traffic_out = c_pat_bad;
        #1;
        tests_run++;
        if (timer_done !== 1'b0) begin tests_failed++; $display("FAIL illegal_done got %b want 0", timer_done); end
        step(1);
        tests_run++;
        if (phase_err !== 1'b1 || remaining !== 8'd2) begin
            tests_failed++;
            $display("FAIL illegal_flag got err=%b rem=%0d want err=1 rem=2", phase_err, remaining);
        end
        step(3);
        tests_run++;
        if (remaining !== 8'd2 || phase !== 2'd0) begin
            tests_failed++;
            $display("FAIL illegal_hold got rem=%0d phase=%0d want rem=2 phase=0", remaining, phase);
        end
        traffic_out = c_pat_garb;
        step(3);
        tests_run++;
        if (remaining !== 8'd0 || timer_done !== 1'b0 || phase_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_failsafe got rem=%0d done=%b err=%b want rem=0 done=0 err=1",
                     remaining, timer_done, phase_err);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (phase_err !== 1'b0 || remaining !== 8'd3 || phase !== 2'd0 || timer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_reset got err=%b rem=%0d phase=%0d done=%b want err=0 rem=3 phase=0 done=0",
                     phase_err, remaining, phase, timer_done);
        end
        step(1);
        rstn = 1'b1;
        traffic_out = c_pat_ragb;
        step(1);
        tests_run++;
        if (phase !== 2'd2 || remaining !== 8'd4) begin
            tests_failed++;
            $display("FAIL dur_revert got phase=%0d rem=%0d want phase=2 rem=4", phase, remaining);
        end
    endtask

    initial begin
        test_reset();
        test_garb_countdown();
        test_phase_change();
        test_config();
        test_freeze();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
